// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, FSM states and default latencies for the MD unit
package mdu_pkg;

  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_arith.sv
// rtl/mdu_arith.sv - combinational multiply/divide result; divider built only with MDU_DIV_EN
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;

  // Sign-extending to 64 bits makes the low 64 bits of an unsigned multiply the signed product.
  assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

`ifdef MDU_DIV_EN
  logic [31:0] mag_a, mag_b, dvs_s, quo_m, rem_m, quo_s, rem_s;
  logic [31:0] dvs_u, quo_u, rem_u;

  // Signed divide on magnitudes; 0x80000000/-1 falls out as quotient 0x80000000, remainder 0.
  assign mag_a = src_a[31] ? -src_a : src_a;
  assign mag_b = src_b[31] ? -src_b : src_b;
  assign dvs_s = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign quo_m = mag_a / dvs_s;
  assign rem_m = mag_a % dvs_s;
  assign quo_s = (src_a[31] ^ src_b[31]) ? -quo_m : quo_m;
  assign rem_s = src_a[31] ? -rem_m : rem_m;

  assign dvs_u = (src_b == 32'd0) ? 32'd1 : src_b;
  assign quo_u = src_a / dvs_u;
  assign rem_u = src_a % dvs_u;
`endif

  always_comb begin
    result   = 64'd0;
    div_zero = 1'b0;
    case (md_op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
`ifdef MDU_DIV_EN
      OP_DIV: begin
        result   = {rem_s, quo_s};
        div_zero = (src_b == 32'd0);
      end
      OP_DIVU: begin
        result   = {rem_u, quo_u};
        div_zero = (src_b == 32'd0);
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - MD sequencing controller (HI/LO, busy counter, D-stage stall); divide via MDU_DIV_EN
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_valid,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_md_use,
  input  logic        hilo_sel,
  output logic [31:0] md_rd,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        md_stall
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [63:0] pend_q;
  logic        pend_wr_q;
  logic [31:0] hi_q, lo_q;

  logic [63:0] arith_res;
  logic        arith_div_zero;
  logic        is_mul, is_div, start_op, start, commit;
  logic [3:0]  load_cnt;

  mdu_arith u_arith (
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .result   (arith_res),
    .div_zero (arith_div_zero)
  );

  assign is_mul = (md_op == OP_MULT) || (md_op == OP_MULTU);
  assign is_div = (md_op == OP_DIV)  || (md_op == OP_DIVU);

`ifdef MDU_DIV_EN
  assign start_op = is_mul || is_div;
`else
  assign start_op = is_mul;
`endif

  assign start    = md_valid && (state_q == IDLE) && start_op;
  assign load_cnt = is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (cnt_q == 4'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == BUSY);
    md_stall = d_md_use && (busy || start);
    commit   = busy && (cnt_q == 4'd1) && pend_wr_q;
    md_rd    = hilo_sel ? hi_q : lo_q;
  end

  // A divide by zero still runs the full latency but never commits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= 4'd0;
      pend_q    <= 64'd0;
      pend_wr_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      if (start) begin
        cnt_q     <= load_cnt;
        pend_q    <= arith_res;
        pend_wr_q <= !arith_div_zero;
      end else if (busy) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (commit) begin
        hi_q <= pend_q[63:32];
        lo_q <= pend_q[31:0];
      end
      if ((state_q == IDLE) && md_valid && (md_op == OP_MTHI)) hi_q <= src_a;
      if ((state_q == IDLE) && md_valid && (md_op == OP_MTLO)) lo_q <= src_a;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide sequencing controller for the pipelined MIPS core, sitting in the E stage beside the ALU. It accepts `mult`/`multu`/`div`/`divu`/`mthi`/`mtlo` from E, holds the HI/LO registers, models the fixed multi-cycle latency with a busy counter, and raises a stall request so the hazard unit freezes D whenever a later MD instruction would touch HI/LO too early.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu` (legal range ≥1).
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu` (legal range ≥1).

- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `md_valid` in 1: the E-stage instruction is real (not a bubble).
- `md_op` in 3: E-stage operation: `NONE`=0, `MULT`=1, `MULTU`=2, `DIV`=3, `DIVU`=4, `MTHI`=5, `MTLO`=6.
- `src_a` in 32: rs operand (forwarded).
- `src_b` in 32: rt operand (forwarded).
- `d_md_use` in 1: the D-stage instruction is any MD instruction (`mult`/`div` family, `mfhi`, `mflo`, `mthi`, `mtlo`).
- `hilo_sel` in 1: read select for `md_rd`; 0 = LO, 1 = HI.
- `md_rd` out 32: combinational read of the selected register, for `mfhi`/`mflo` in E.
- `hi` out 32: registered HI.
- `lo` out 32: registered LO.
- `busy` out 1: registered; high while an operation is in flight.
- `md_stall` out 1: combinational stall request to the hazard unit.

## Operation
- FSM has two states: `IDLE` and `BUSY`. An internal 4-bit down-counter `cnt` and a 64-bit `pend` result register hold the in-flight operation.
- In `IDLE`, when `md_valid` is high and the op is `MULT`/`MULTU`/`DIV`/`DIVU` (a start):
  - `pend` captures the result.
  - `cnt` loads `MULT_CYCLES` or `DIV_CYCLES`.
  - The FSM moves to `BUSY`.
- In `BUSY`, `cnt` decrements each cycle. On the cycle with `cnt==1`:
  - `{HI,LO}` is written from `pend`.
  - The FSM returns to `IDLE`.
- `MTHI`/`MTLO` in `IDLE` write `src_a` to HI/LO at the edge. They are single-cycle and do not assert `busy`.
- Any `md_valid` op while in `BUSY` is ignored. The `md_stall` protocol makes this unreachable.
- `md_stall = d_md_use & (busy | start)`, where `start` is the combinational start condition above.
- Arithmetic:
  - `MULT`: `{HI,LO}` = signed 64-bit product.
  - `MULTU`: `{HI,LO}` = unsigned 64-bit product.
  - `DIV`: LO = quotient truncated toward zero; HI = remainder, carrying the dividend's sign.
  - `DIVU`: unsigned quotient in LO, remainder in HI.
  - `0x80000000 / -1` (signed): LO=0x80000000, HI=0.
  - Divide by zero: takes the full `DIV_CYCLES`, but HI/LO keep their previous values.

## Timing
- Reset (`reset`=0 at an edge) → state `IDLE`, `cnt`=0, `pend`=0, `hi`=`lo`=0, `busy`=0. This applies equally mid-operation: the in-flight result is discarded.
- Start accepted at the edge ending cycle T:
  - `busy`=1 during cycles T+1 … T+N.
  - HI/LO hold the new value from cycle T+N+1, when `busy`=0.
- `md_stall` is already high in cycle T if D holds an MD instruction. It stays high through T+N and drops in T+N+1.
- `md_rd` reflects HI/LO combinationally. A write at an edge is visible in the next cycle.
- A start and an `MTHI` cannot coincide: there is one E-stage op per cycle.

## Configuration
- Macro: `MDU_DIV_EN`.
- Defined: full division support as specified.
- Undefined: no divider logic is built. `DIV`/`DIVU` are treated as `NONE`: no busy, HI/LO unchanged, no stall contribution. `DIV_CYCLES` is unused.

## Structure
- Shared package `mdu_pkg` holds:
  - the `md_op` encodings;
  - the `IDLE`/`BUSY` state constants;
  - the default latencies.
- One combinational sub-module, `mdu_arith`:
  - inputs: `md_op`, `src_a`, `src_b`;
  - outputs: the 64-bit `{hi,lo}` result and a `div_zero` flag;
  - the divider part is guarded by `MDU_DIV_EN`.
- `mdu_ctrl` owns the FSM, counter, `pend`, HI/LO and stall logic.

## Test plan
- `MULT` 3 × 0xFFFFFFFE → `busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- `MULTU` 0xFFFFFFFF × 2 → HI=0x00000001, LO=0xFFFFFFFE. With `d_md_use`=1 held, `md_stall` is high from the issue cycle through the last busy cycle and low one cycle later.
- `DIV` 0xFFFFFFF9 (−7) / 2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. `DIVU` 7/2 → LO=3, HI=1.
- `MTHI` 0x1234 then `MTLO` 0x5678, then `DIV` x/0 → `busy` high 10 cycles; HI=0x1234, LO=0x5678 unchanged; `md_rd` returns these for `hilo_sel`=1/0.
- `MULT` 5×5 with `reset`=0 in the 3rd busy cycle → next cycle `busy`=0, HI=LO=0. After reset release, an `MTLO` 7 gives LO=7 with no stall.
- Build without `MDU_DIV_EN`: `DIV` 10/2 → `busy` stays 0, `md_stall`=0, HI/LO unchanged.
